// File: rtl/lane_game_ctrl.sv
// Game-state controller for the three-lane runner: lane moves, obstacle descent,
// respawn with speed ramp, collision detection and scoring, paced by frame_tick.
module lane_game_ctrl #(
    parameter int LANE_L_X   = 80,
    parameter int LANE_M_X   = 300,
    parameter int LANE_R_X   = 520,
    parameter int PLAYER_Y   = 280,
    parameter int PLAYER_H   = 100,
    parameter int OBST_H     = 50,
    parameter int SCREEN_H   = 480,
    parameter int OBST_PARK  = 600,
    parameter int SPEED_INIT = 2,
    parameter int SPEED_MAX  = 8,
    parameter int SPEED_STEP = 4
) (
    input  logic       clk_div,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    output logic [9:0] object_x,
    output logic [9:0] obstacle_y,
    output logic [1:0] obstacle_lane,
    output logic       playing,
    output logic       game_over,
    output logic [7:0] score
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t      state, state_nx;
    logic [2:0]  btn_s1, btn_s2, btn_prev, btn_ev;
    logic        ev_left, ev_right, ev_start;
    logic [7:0]  lfsr;
    logic [1:0]  new_lane;
    logic [1:0]  player_lane, player_lane_nx;
    logic [9:0]  obstacle_y_nx;
    logic [1:0]  obstacle_lane_nx;
    logic [7:0]  score_nx, score_inc;
    logic [3:0]  speed, speed_nx;
    logic [10:0] y_sum;
    logic        respawn, ramp, hit;

    // Button vectors are ordered {start, right, left}.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
        end else begin
            btn_s1   <= {btn_start, btn_right, btn_left};
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    assign btn_ev   = btn_s2 & ~btn_prev;
    assign ev_left  = btn_ev[0];
    assign ev_right = btn_ev[1];
    assign ev_start = btn_ev[2];

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Code 3 folds onto the middle lane, so the middle lane is twice as likely.
    always_comb begin
        case (lfsr[1:0])
            2'd0:    new_lane = 2'd0;
            2'd2:    new_lane = 2'd2;
            default: new_lane = 2'd1;
        endcase
    end

    assign y_sum     = {1'b0, obstacle_y} + {7'd0, speed};
    assign respawn   = (y_sum >= 11'(SCREEN_H));
    assign score_inc = (score == 8'hFF) ? score : score + 8'd1;
    assign ramp      = (score_inc != 8'd0) && ((score_inc % 8'(SPEED_STEP)) == 8'd0);
    assign hit       = (player_lane == obstacle_lane)
                    && ({1'b0, obstacle_y} < 11'(PLAYER_Y + PLAYER_H))
                    && (({1'b0, obstacle_y} + 11'(OBST_H)) > 11'(PLAYER_Y));

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            player_lane   <= 2'd1;
            obstacle_y    <= 10'(OBST_PARK);
            obstacle_lane <= 2'd1;
            score         <= 8'd0;
            speed         <= 4'(SPEED_INIT);
        end else begin
            state         <= state_nx;
            player_lane   <= player_lane_nx;
            obstacle_y    <= obstacle_y_nx;
            obstacle_lane <= obstacle_lane_nx;
            score         <= score_nx;
            speed         <= speed_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        player_lane_nx   = player_lane;
        obstacle_y_nx    = obstacle_y;
        obstacle_lane_nx = obstacle_lane;
        score_nx         = score;
        speed_nx         = speed;
        playing          = 1'b0;
        game_over        = 1'b0;
        case (state)
            IDLE: begin
                if (ev_start) begin
                    state_nx         = PLAY;
                    obstacle_y_nx    = 10'd0;
                    obstacle_lane_nx = new_lane;
                    score_nx         = 8'd0;
                    speed_nx         = 4'(SPEED_INIT);
                    player_lane_nx   = 2'd1;
                end
            end
            PLAY: begin
                playing = 1'b1;
                // A collision freezes everything, including a coincident move or frame.
                if (hit) begin
                    state_nx = OVER;
                end else begin
                    if (ev_left && !ev_right && player_lane != 2'd0) begin
                        player_lane_nx = player_lane - 2'd1;
                    end else if (ev_right && !ev_left && player_lane != 2'd2) begin
                        player_lane_nx = player_lane + 2'd1;
                    end
                    if (frame_tick) begin
                        if (respawn) begin
                            obstacle_y_nx    = 10'd0;
                            obstacle_lane_nx = new_lane;
                            score_nx         = score_inc;
                            if (ramp && speed < 4'(SPEED_MAX)) begin
                                speed_nx = speed + 4'd1;
                            end
                        end else begin
                            obstacle_y_nx = y_sum[9:0];
                        end
                    end
                end
            end
            OVER: begin
                game_over = 1'b1;
                if (ev_start) begin
                    state_nx         = IDLE;
                    obstacle_y_nx    = 10'(OBST_PARK);
                    obstacle_lane_nx = 2'd1;
                    player_lane_nx   = 2'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        case (player_lane)
            2'd0:    object_x = 10'(LANE_L_X);
            2'd2:    object_x = 10'(LANE_R_X);
            default: object_x = 10'(LANE_M_X);
        endcase
    end

endmodule

// File: tb/tb_lane_game_ctrl.sv
// Self-checking bench for lane_game_ctrl: every cycle is compared against a
// behavioural game model, plus directed lane, ramp, collision and reset scenarios.
module tb_lane_game_ctrl;

    logic       clk_div = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_start;
    logic [9:0] object_x;
    logic [9:0] obstacle_y;
    logic [1:0] obstacle_lane;
    logic       playing;
    logic       game_over;
    logic [7:0] score;

    int checks   = 0;
    int failures = 0;

    lane_game_ctrl dut (
        .clk_div      (clk_div),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_start    (btn_start),
        .object_x     (object_x),
        .obstacle_y   (obstacle_y),
        .obstacle_lane(obstacle_lane),
        .playing      (playing),
        .game_over    (game_over),
        .score        (score)
    );

    always #5 clk_div = ~clk_div;

    typedef enum int {M_IDLE, M_PLAY, M_OVER} mstate_t;

    mstate_t    m_state;
    int         m_lane, m_olane, m_y, m_score, m_speed;
    logic [7:0] m_lfsr;
    logic [2:0] h_left, h_right, h_start;

    typedef struct {
        logic l;
        logic r;
        int   exp_x;
    } lane_vec_t;

    lane_vec_t lane_tab [8];

    function automatic int lane_x(input int l);
        return (l == 0) ? 80 : (l == 1) ? 300 : 520;
    endfunction

    function automatic int lfsr_lane(input logic [7:0] v);
        return (v[1:0] == 2'd0) ? 0 : (v[1:0] == 2'd2) ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_lane  = 1;
        m_olane = 1;
        m_y     = 600;
        m_score = 0;
        m_speed = 2;
        m_lfsr  = 8'hA5;
        h_left  = '0;
        h_right = '0;
        h_start = '0;
    endtask

    // One clock edge of the game, evaluated from the inputs about to be sampled.
    task automatic model_edge();
        bit ev_l, ev_r, ev_s, hit;
        ev_l = h_left[1]  && !h_left[2];
        ev_r = h_right[1] && !h_right[2];
        ev_s = h_start[1] && !h_start[2];
        hit  = (m_lane == m_olane) && (m_y < 380) && (m_y + 50 > 280);
        case (m_state)
            M_IDLE: if (ev_s) begin
                m_state = M_PLAY;
                m_y     = 0;
                m_olane = lfsr_lane(m_lfsr);
                m_score = 0;
                m_speed = 2;
                m_lane  = 1;
            end
            M_PLAY: if (hit) begin
                m_state = M_OVER;
            end else begin
                if (ev_l && !ev_r && m_lane > 0) m_lane = m_lane - 1;
                else if (ev_r && !ev_l && m_lane < 2) m_lane = m_lane + 1;
                if (frame_tick) begin
                    if (m_y + m_speed >= 480) begin
                        m_y     = 0;
                        m_olane = lfsr_lane(m_lfsr);
                        if (m_score < 255) m_score = m_score + 1;
                        if (m_score % 4 == 0 && m_speed < 8) m_speed = m_speed + 1;
                    end else begin
                        m_y = m_y + m_speed;
                    end
                end
            end
            default: if (ev_s) begin
                m_state = M_IDLE;
                m_y     = 600;
                m_olane = 1;
                m_lane  = 1;
            end
        endcase
        h_left  = {h_left[1:0], btn_left};
        h_right = {h_right[1:0], btn_right};
        h_start = {h_start[1:0], btn_start};
        m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic check_output(input string name);
        checks++;
        if (object_x !== 10'(lane_x(m_lane)) || obstacle_y !== 10'(m_y) ||
            obstacle_lane !== 2'(m_olane) || playing !== (m_state == M_PLAY) ||
            game_over !== (m_state == M_OVER) || score !== 8'(m_score)) begin
            failures++;
            $display("[TB] FAIL %s @%0t: got x=%0d y=%0d lane=%0d play=%0b over=%0b score=%0d, expected x=%0d y=%0d lane=%0d play=%0b over=%0b score=%0d",
                     name, $time, object_x, obstacle_y, obstacle_lane, playing, game_over, score,
                     lane_x(m_lane), m_y, m_olane, m_state == M_PLAY, m_state == M_OVER, m_score);
        end
    endtask

    task automatic check_value(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic l, input logic r, input logic s, input logic f);
        btn_left   = l;
        btn_right  = r;
        btn_start  = s;
        frame_tick = f;
        model_edge();
        @(posedge clk_div);
        #1;
        check_output("cycle");
    endtask

    task automatic press(input logic l, input logic r, input logic s);
        apply_stimulus(l, r, s, 1'b0);
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_output(name);
        @(posedge clk_div);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int prev_y, prev_score, step, max_step, saved_x;
        bit wrap_checked, step3_checked;

        lane_tab[0] = '{1'b1, 1'b0, 80};
        lane_tab[1] = '{1'b1, 1'b0, 80};
        lane_tab[2] = '{1'b0, 1'b1, 300};
        lane_tab[3] = '{1'b0, 1'b1, 520};
        lane_tab[4] = '{1'b0, 1'b1, 520};
        lane_tab[5] = '{1'b1, 1'b1, 520};
        lane_tab[6] = '{1'b1, 1'b0, 300};
        lane_tab[7] = '{1'b1, 1'b1, 300};

        rst_n      = 1'b1;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_start  = 1'b0;
        frame_tick = 1'b0;
        #1;
        do_reset("reset_init");
        check_value("reset_x", int'(object_x), 300);
        check_value("reset_y", int'(obstacle_y), 600);
        check_value("reset_lane", int'(obstacle_lane), 1);
        check_value("reset_score", int'(score), 0);

        // Start pulse sampled at edge N must take effect at edge N+2.
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_value("start_not_yet", int'(playing), 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_value("start_playing", int'(playing), 1);
        check_value("start_y", int'(obstacle_y), 0);
        check_value("start_score", int'(score), 0);

        repeat (10) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_value("ten_frames_y", int'(obstacle_y), 20);

        for (int i = 0; i < 8; i++) begin
            press(lane_tab[i].l, lane_tab[i].r, 1'b0);
            check_value($sformatf("lane_vec%0d", i), int'(object_x), lane_tab[i].exp_x);
        end

        repeat (1000) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_value("hold_left_x", int'(object_x), 80);

        // Dodge obstacles while the speed ramps up to score 40.
        wrap_checked  = 1'b0;
        step3_checked = 1'b0;
        max_step      = 0;
        for (int f = 0; f < 6000 && m_score < 40 && m_state == M_PLAY; f++) begin
            prev_y     = int'(obstacle_y);
            prev_score = int'(score);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
            if (int'(score) == prev_score) begin
                step = int'(obstacle_y) - prev_y;
                if (step > max_step) max_step = step;
            end
            if (!wrap_checked && int'(score) == 1) begin
                wrap_checked = 1'b1;
                check_value("wrap_prev_y", prev_y, 478);
                check_value("wrap_y", int'(obstacle_y), 0);
            end
            if (!step3_checked && prev_score == 4 && prev_y == 0) begin
                step3_checked = 1'b1;
                check_value("speed3_step", int'(obstacle_y), 3);
            end
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (m_olane == m_lane) press(m_lane != 0 ? 1'b1 : 1'b0, m_lane == 0 ? 1'b1 : 1'b0, 1'b0);
        end
        check_value("ramp_score", int'(score), 40);
        check_value("ramp_max_step", max_step, 8);
        check_value("ramp_still_playing", int'(playing), 1);

        // Steer into the obstacle and let it hit at y=232 with frame_tick held high.
        for (int i = 0; i < 3 && m_lane != m_olane; i++) begin
            press(m_olane < m_lane ? 1'b1 : 1'b0, m_olane > m_lane ? 1'b1 : 1'b0, 1'b0);
        end
        for (int i = 0; i < 100 && !game_over; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_value("collide_over", int'(game_over), 1);
        check_value("collide_y", int'(obstacle_y), 232);
        saved_x = lane_x(m_lane);
        repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check_value("frozen_y", int'(obstacle_y), 232);
        check_value("frozen_x", int'(object_x), saved_x);
        check_value("frozen_score", int'(score), 40);

        press(1'b0, 1'b0, 1'b1);
        check_value("restart_idle_play", int'(playing), 0);
        check_value("restart_idle_over", int'(game_over), 0);
        check_value("restart_x", int'(object_x), 300);
        check_value("restart_y", int'(obstacle_y), 600);
        check_value("restart_score_kept", int'(score), 40);
        press(1'b0, 1'b0, 1'b1);
        check_value("replay_score", int'(score), 0);
        check_value("replay_playing", int'(playing), 1);

        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                           $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1);
        end

        do_reset("reset_pre_async");
        press(1'b0, 1'b0, 1'b1);
        repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        check_value("async_pre_playing", int'(playing), 1);
        #2;
        do_reset("async_reset");
        check_value("async_x", int'(object_x), 300);
        check_value("async_y", int'(obstacle_y), 600);
        check_value("async_playing", int'(playing), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
